// File: rtl/hbv2_spi_pkg.sv
// hbv2_spi_pkg: shared types, defaults and sizing helper for the SPI target FIFO block.
package hbv2_spi_pkg;

    typedef enum logic {IDLE, ACTIVE} state_e;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH = 4;
    localparam logic [7:0] DEF_TX_IDLE = 8'hFF;

    function automatic int occ_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/hbv2_spi_sync.sv
// hbv2_spi_sync: 2-flop synchronizer with optional third flop for edge detection.
//   clk_i, rst_ni : clock, async active-low reset (flops reset to RST_VAL)
//   d_i           : asynchronous input
//   q_o           : synchronized level
//   rise_o/fall_o : one-cycle edge pulses of q_o (tied low when EDGE=0)
module hbv2_spi_sync #(
    parameter logic RST_VAL = 1'b0,
    parameter bit EDGE = 1'b1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic [1:0] s;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) s <= {2{RST_VAL}};
        else s <= {s[0], d_i};
    end

    assign q_o = s[1];

    if (EDGE) begin : g_edge
        logic prev;
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) prev <= RST_VAL;
            else prev <= s[1];
        end
        assign rise_o = s[1] && !prev;
        assign fall_o = !s[1] && prev;
    end else begin : g_no_edge
        assign rise_o = 1'b0;
        assign fall_o = 1'b0;
    end

endmodule

// File: rtl/hbv2_spi_slave_fifo.sv
// hbv2_spi_slave_fifo: SPI mode-0 target with RX FIFO and a one-byte TX holding register.
//   clk_i, rst_ni, clr_i         : clock, async active-low reset, sync clear
//   spi_sclk_i/cs_ni/mosi_i      : SPI pins, asynchronous to clk_i
//   spi_miso_o, spi_miso_oe_o    : serial out and its enable (synchronized CS low)
//   rx_data_o/valid_o/ready_i    : FIFO head, valid/ready consumer side
//   tx_data_i/valid_i/ready_o    : TX holding register write port
//   elements_o, overflow_o       : FIFO occupancy, sticky dropped-byte flag
module hbv2_spi_slave_fifo import hbv2_spi_pkg::*; #(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH = DEF_DEPTH,
    parameter logic [DATA_W-1:0] TX_IDLE = DATA_W'(DEF_TX_IDLE)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     clr_i,
    input  logic                     spi_sclk_i,
    input  logic                     spi_cs_ni,
    input  logic                     spi_mosi_i,
    output logic                     spi_miso_o,
    output logic                     spi_miso_oe_o,
    output logic [DATA_W-1:0]        rx_data_o,
    output logic                     rx_valid_o,
    input  logic                     rx_ready_i,
    input  logic [DATA_W-1:0]        tx_data_i,
    input  logic                     tx_valid_i,
    output logic                     tx_ready_o,
    output logic [occ_w(DEPTH)-1:0]  elements_o,
    output logic                     overflow_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DATA_W);
    localparam int OW = occ_w(DEPTH);

    logic unused_sclk, unused_mosi_rise, unused_mosi_fall;
    logic sclk_rise, sclk_fall, cs_n, cs_rise, cs_fall, mosi;
    state_e state, state_next;
    logic start, active, byte_done, load, accept, pop, full, wr_en, hold_full;
    logic [CW-1:0] bit_cnt;
    logic [DATA_W-1:0] rx_shift, tx_shift, hold_data, rx_byte, load_val;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [OW-1:0] elements;

    hbv2_spi_sync #(.RST_VAL(1'b0), .EDGE(1'b1)) u_sclk (
        .clk_i(clk_i), .rst_ni(rst_ni), .d_i(spi_sclk_i),
        .q_o(unused_sclk), .rise_o(sclk_rise), .fall_o(sclk_fall)
    );
    hbv2_spi_sync #(.RST_VAL(1'b1), .EDGE(1'b1)) u_cs (
        .clk_i(clk_i), .rst_ni(rst_ni), .d_i(spi_cs_ni),
        .q_o(cs_n), .rise_o(cs_rise), .fall_o(cs_fall)
    );
    hbv2_spi_sync #(.RST_VAL(1'b0), .EDGE(1'b0)) u_mosi (
        .clk_i(clk_i), .rst_ni(rst_ni), .d_i(spi_mosi_i),
        .q_o(mosi), .rise_o(unused_mosi_rise), .fall_o(unused_mosi_fall)
    );

    always_comb begin
        start = state == IDLE && cs_fall;
        state_next = start ? ACTIVE : (state == ACTIVE && cs_rise) ? IDLE : state;
    end

    assign active = state == ACTIVE;
    assign byte_done = active && sclk_rise && bit_cnt == CW'(DATA_W - 1);
    assign rx_byte = {rx_shift[DATA_W-2:0], mosi};
    // A TX load happens at frame start and on every completed byte; it drains the holding register.
    assign load = start || byte_done;
    assign load_val = hold_full ? hold_data : TX_IDLE;
    assign accept = tx_valid_i && !hold_full;
    assign pop = rx_valid_o && rx_ready_i;
    assign full = elements == OW'(DEPTH);
    // A byte arriving while full is only stored if a pop frees the slot in the same cycle.
    assign wr_en = byte_done && (!full || pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
            bit_cnt <= '0;
            rx_shift <= '0;
            tx_shift <= TX_IDLE;
            hold_full <= 1'b0;
            hold_data <= '0;
        end else if (clr_i) begin
            state <= IDLE;
            bit_cnt <= '0;
            tx_shift <= TX_IDLE;
            hold_full <= 1'b0;
        end else begin
            state <= state_next;
            if (start) bit_cnt <= '0;
            else if (active && sclk_rise) bit_cnt <= byte_done ? '0 : bit_cnt + 1'b1;
            if (active && sclk_rise) rx_shift <= rx_byte;
            // No shift on the falling edge that follows a byte boundary: the fresh MSB must stay on MISO.
            tx_shift <= load ? load_val : (active && sclk_fall && bit_cnt != '0) ? tx_shift << 1 : tx_shift;
            if (load && hold_full) hold_full <= 1'b0;
            else if (accept) begin
                hold_full <= 1'b1;
                hold_data <= tx_data_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            elements <= '0;
            overflow_o <= 1'b0;
        end else if (clr_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            elements <= '0;
            overflow_o <= 1'b0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= rx_byte;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (byte_done && !wr_en) overflow_o <= 1'b1;
            elements <= elements + OW'(wr_en) - OW'(pop);
        end
    end

    assign rx_data_o = mem[rd_ptr];
    assign rx_valid_o = elements != '0;
    assign elements_o = elements;
    assign tx_ready_o = !hold_full;
    assign spi_miso_o = tx_shift[DATA_W-1];
    assign spi_miso_oe_o = !cs_n;

endmodule
